// File: rtl/clock12_pkg.sv
// Shared state encoding, BCD limits and parameter defaults for the 12-hour alarm.
package clock12_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RINGING = 2'd2,
        ST_SNOOZE  = 2'd3
    } alarm_state_t;

    localparam logic [7:0] BCD_HH_MIN = 8'h01;
    localparam logic [7:0] BCD_HH_MAX = 8'h12;
    localparam logic [7:0] BCD_MM_MIN = 8'h00;
    localparam logic [7:0] BCD_MM_MAX = 8'h59;

    localparam int RING_TICKS_DEF   = 60;
    localparam int SNOOZE_TICKS_DEF = 300;
    localparam int MAX_SNOOZE_DEF   = 3;

    // Legal BCD digits keep numeric order, so a plain range compare is enough.
    function automatic logic bcd_in_range(input logic [7:0] v,
                                          input logic [7:0] lo,
                                          input logic [7:0] hi);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/tick_downcounter.sv
// Loadable down-counter stepped by the seconds tick; flags the tick that empties it.
module tick_downcounter #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expire
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (ena && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    // An already-empty counter also expires, so a stale zero can never stall a ring.
    assign expire = ena && (count <= WIDTH'(1));

endmodule

// File: rtl/clock12_alarm.sv
// Alarm controller for a 12-hour BCD clock: stored alarm time, ring/snooze FSM.
//
//  state      | meaning
//  -----------+----------------------------------------------
//  ST_IDLE    | arm low, alarm inactive
//  ST_ARMED   | waiting for the rising edge of a time match
//  ST_RINGING | ringing, counting RING_TICKS seconds
//  ST_SNOOZE  | snoozed, counting SNOOZE_TICKS seconds
module clock12_alarm
    import clock12_pkg::*;
#(
    parameter int RING_TICKS   = RING_TICKS_DEF,
    parameter int SNOOZE_TICKS = SNOOZE_TICKS_DEF,
    parameter int MAX_SNOOZE   = MAX_SNOOZE_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic       pm,
    input  logic [7:0] hh,
    input  logic [7:0] mm,
    input  logic [7:0] ss,
    input  logic       set_en,
    input  logic       set_pm,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    input  logic       arm,
    input  logic       snooze,
    input  logic       dismiss,
    output logic       ringing,
    output logic       snoozing,
    output logic       set_err,
    output logic [1:0] snooze_left
);

    localparam int CNT_MAX = (RING_TICKS > SNOOZE_TICKS) ? RING_TICKS : SNOOZE_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    alarm_state_t     state, state_nx;
    logic             a_pm;
    logic [7:0]       a_hh, a_mm;
    logic             match_c, match_q, match_rise;
    logic             set_ok;
    logic             cnt_load, cnt_expire;
    logic [CNT_W-1:0] cnt_val;
    logic [1:0]       sl_nx;

    assign set_ok = bcd_in_range(set_hh, BCD_HH_MIN, BCD_HH_MAX)
                 && bcd_in_range(set_mm, BCD_MM_MIN, BCD_MM_MAX);

    assign match_c    = (pm == a_pm) && (hh == a_hh) && (mm == a_mm) && (ss == 8'h00);
    assign match_rise = match_c && !match_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_pm    <= 1'b0;
            a_hh    <= BCD_HH_MAX;
            a_mm    <= 8'h00;
            set_err <= 1'b0;
            match_q <= 1'b0;
        end else begin
            if (set_en && set_ok) begin
                a_pm <= set_pm;
                a_hh <= set_hh;
                a_mm <= set_mm;
            end
            set_err <= set_en && !set_ok;
            match_q <= match_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            snooze_left <= 2'd0;
        end else begin
            state       <= state_nx;
            snooze_left <= sl_nx;
        end
    end

    // Priority: arm low > set_en > dismiss > snooze > expiry > match.
    always_comb begin
        state_nx = state;
        sl_nx    = snooze_left;
        cnt_load = 1'b0;
        cnt_val  = '0;
        if (!arm) begin
            state_nx = ST_IDLE;
        end else if (set_en) begin
            if (set_ok) state_nx = ST_ARMED;
        end else begin
            case (state)
                ST_IDLE: state_nx = ST_ARMED;
                ST_ARMED: begin
                    if (match_rise) begin
                        state_nx = ST_RINGING;
                        sl_nx    = 2'(MAX_SNOOZE);
                        cnt_load = 1'b1;
                        cnt_val  = CNT_W'(RING_TICKS);
                    end
                end
                ST_RINGING: begin
                    if (dismiss) begin
                        state_nx = ST_ARMED;
                    end else if (snooze) begin
                        if (snooze_left != 2'd0) begin
                            state_nx = ST_SNOOZE;
                            sl_nx    = snooze_left - 2'd1;
                            cnt_load = 1'b1;
                            cnt_val  = CNT_W'(SNOOZE_TICKS);
                        end else begin
                            state_nx = ST_ARMED;
                        end
                    end else if (cnt_expire) begin
                        state_nx = ST_ARMED;
                    end
                end
                ST_SNOOZE: begin
                    if (dismiss) begin
                        state_nx = ST_ARMED;
                    end else if (cnt_expire) begin
                        state_nx = ST_RINGING;
                        cnt_load = 1'b1;
                        cnt_val  = CNT_W'(RING_TICKS);
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ringing  = 1'b0;
        snoozing = 1'b0;
        case (state)
            ST_RINGING: ringing  = 1'b1;
            ST_SNOOZE:  snoozing = 1'b1;
            default: ;
        endcase
    end

    tick_downcounter #(.WIDTH(CNT_W)) u_ticks (
        .clk      (clk),
        .reset    (reset),
        .ena      (ena),
        .load     (cnt_load),
        .load_val (cnt_val),
        .expire   (cnt_expire)
    );

endmodule

// File: doc/clock12_alarm.md
CLOCK12_ALARM -- requirements
Module: clock12_alarm

Interface
REQ-001 SHALL have parameter RING_TICKS, default 60, meaning ena ticks a ring lasts before auto-silence.
REQ-002 SHALL have parameter SNOOZE_TICKS, default 300, meaning ena ticks spent in snooze before re-ringing.
REQ-003 SHALL have parameter MAX_SNOOZE, default 3, meaning snoozes allowed per alarm event.
REQ-004 SHALL have ports: clk in 1, sole clock, rising edge; reset in 1, synchronous, active-high.
REQ-005 SHALL have ports: ena in 1, one-cycle seconds tick shared with the 12-hour clock; pm in 1; hh in 8, BCD 01..12; mm in 8, BCD 00..59; ss in 8, BCD 00..59; all from the 12-hour clock.
REQ-006 SHALL have ports: set_en in 1, load strobe; set_pm in 1; set_hh in 8, BCD; set_mm in 8, BCD.
REQ-007 SHALL have ports: arm in 1, level enable; snooze in 1, one-cycle pulse; dismiss in 1, one-cycle pulse.
REQ-008 SHALL have outputs: ringing 1; snoozing 1; set_err 1, one-cycle pulse; snooze_left 2, remaining snoozes.

Function
REQ-009 SHALL hold alarm time registers (a_pm, a_hh, a_mm) loaded on set_en only when set_hh is in 01..12 and set_mm is in 00..59 with both BCD nibbles legal.
REQ-010 SHALL ignore an illegal set request, keep the stored time, and pulse set_err for exactly one cycle, one cycle after set_en.
REQ-011 SHALL implement FSM states IDLE, ARMED, RINGING, SNOOZE.
REQ-012 SHALL define match as pm==a_pm, hh==a_hh, mm==a_mm and ss==8'h00, compared combinationally.
REQ-013 SHALL register match and trigger only on its rising edge, so each alarm minute triggers at most once.
REQ-014 SHALL take ARMED->RINGING on the match rising edge, with ringing high the next cycle; this load sets snooze_left to MAX_SNOOZE and the tick counter to RING_TICKS.
REQ-015 SHALL decrement the tick counter in RINGING on each ena and go to ARMED when it reaches 0.
REQ-016 SHALL take RINGING->SNOOZE on snooze when snooze_left>0, decrement snooze_left, and load SNOOZE_TICKS.
REQ-017 SHALL treat snooze with snooze_left==0 as dismiss.
REQ-018 SHALL take SNOOZE->RINGING when the counter expires on ena and reload RING_TICKS.
REQ-019 SHALL take RINGING or SNOOZE to ARMED on dismiss.
REQ-020 SHALL move any state to IDLE the cycle after arm is low, and IDLE->ARMED when arm is high.
REQ-021 SHALL apply per-cycle priority: reset > arm low > set_en > dismiss > snooze > counter expiry > match.
REQ-022 SHALL, on a valid set_en, force the FSM to ARMED when arm is high, abandoning any ring or snooze; an invalid set_en SHALL not change state.
REQ-023 SHALL drive ringing high only in RINGING and snoozing high only in SNOOZE, both registered.
REQ-024 SHALL leave the counter unchanged on cycles without ena; a RINGING lasts RING_TICKS ena pulses regardless of clk:ena ratio.
REQ-025 SHALL ignore snooze and dismiss pulses in IDLE and ARMED.

Reset
REQ-026 SHALL, on reset, set state IDLE, ringing 0, snoozing 0, set_err 0, snooze_left 0, counter 0, and the match register 0.
REQ-027 SHALL reset the alarm time to 12:00 AM (a_pm=0, a_hh=8'h12, a_mm=8'h00).
REQ-028 SHALL have reset asserted mid-ring drop ringing on the next edge, and SHALL NOT retrigger in the same minute until after match deasserts.

Structure
REQ-029 SHALL place the FSM state encoding, BCD limit constants (8'h12, 8'h59) and parameter defaults in shared package clock12_pkg.
REQ-030 SHALL implement the loadable down-counter decremented on ena as sub-module tick_downcounter, width from the larger tick parameter.
REQ-031 SHALL target 120-400 RTL lines with no latches and no other clock domains.

Verification
REQ-032 SHALL verify: set 07:30 PM, arm=1, drive 07:30:00 PM -> ringing=1 the cycle after; ringing=0 after 60 ena ticks; state ARMED.
REQ-033 SHALL verify: while ringing, snooze -> snoozing=1, snooze_left=2; after 300 ena -> ringing=1; three snoozes then a fourth snooze -> ARMED, ringing=0.
REQ-034 SHALL verify: set_hh=8'h13 or set_mm=8'h5A -> set_err one-cycle pulse, alarm time unchanged, re-match on old time still rings.
REQ-035 SHALL verify: dismiss at 07:30:00 while ss still 00 -> no retrigger; next day 07:30:00 PM -> rings again.
REQ-036 SHALL verify: arm low during SNOOZE -> IDLE next cycle, no ring at the expiry point; reset mid-ring -> all outputs zero next edge.
REQ-037 SHALL verify: set_en and dismiss in the same cycle while ringing -> new time loaded, state ARMED; snooze and arm low together -> IDLE.
